// File: rtl/apb_input_sampler.sv
// APB input sampler: synchronizes NUM_PORTS byte-wide inputs, records rising and
// falling edges, and snapshots every input change into a FIFO readable over APB.
module apb_input_sampler #(
    parameter int NUM_PORTS   = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    input  logic                   PWRITE,
    input  logic [4:0]             PADDR,
    input  logic [7:0]             PWDATA,
    output logic [7:0]             PRDATA,
    output logic                   PREADY,
    input  logic [8*NUM_PORTS-1:0] PIN,
    output logic                   IRQ
);
    localparam int         W         = 8 * NUM_PORTS;
    localparam int         PW        = $clog2(FIFO_DEPTH);
    localparam logic [2:0] ARM_DONE  = 3'(SYNC_STAGES + 1);
    localparam logic [4:0] DEPTH_CNT = 5'(FIFO_DEPTH);

    logic [W-1:0]  r_sync [SYNC_STAGES];
    logic [W-1:0]  r_prev;
    logic [2:0]    r_arm;
    logic [W-1:0]  r_rise;
    logic [W-1:0]  r_fall;
    logic [W-1:0]  r_irqen;
    logic          r_capen;
    logic          r_ovf;
    logic          r_irq;
    logic [7:0]    r_prdata;
    logic [W-1:0]  r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [4:0]    r_count;

    logic [W-1:0]  w_live;
    logic [W-1:0]  w_head;
    logic [W-1:0]  w_rise_set;
    logic [W-1:0]  w_fall_set;
    logic [W-1:0]  w_rise_clr;
    logic [W-1:0]  w_fall_clr;
    logic          w_armed;
    logic          w_acc_wr;
    logic          w_setup_rd;
    logic          w_full;
    logic          w_empty;
    logic          w_flush;
    logic          w_pop_req;
    logic          w_do_pop;
    logic          w_push_req;
    logic          w_do_push;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic [7:0]    w_stat;
    logic [7:0]    w_rdata;

    assign w_live     = r_sync[SYNC_STAGES-1];
    assign w_armed    = (r_arm == ARM_DONE);
    assign w_acc_wr   = PSEL & PENABLE & PWRITE;
    assign w_setup_rd = PSEL & ~PENABLE & ~PWRITE;
    assign w_full     = (r_count == DEPTH_CNT);
    assign w_empty    = (r_count == 5'd0);
    assign w_head     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign w_stat     = {r_ovf, w_full, w_empty, r_count};

    // Edges are only trusted once the synchronizer and PREV hold post-reset samples.
    assign w_rise_set = w_armed ? (w_live & ~r_prev) : '0;
    assign w_fall_set = w_armed ? (~w_live & r_prev) : '0;

    assign w_flush    = w_acc_wr && (PADDR == 5'h11) && PWDATA[1];
    assign w_pop_req  = w_acc_wr && (PADDR == 5'h12);
    assign w_do_pop   = w_pop_req && !w_empty;
    assign w_push_req = w_armed && r_capen && (w_live != r_prev);
    assign w_do_push  = w_push_req && (!w_full || w_do_pop);
    assign w_ovf_set  = w_push_req && w_full && !w_do_pop && !w_flush;
    assign w_ovf_clr  = w_acc_wr && (PADDR == 5'h10) && PWDATA[7];

    assign PREADY = 1'b1;
    assign PRDATA = r_prdata;
    assign IRQ    = r_irq;

    always_comb begin
        w_rise_clr = '0;
        w_fall_clr = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_acc_wr && (PADDR == 5'(4 + p))) w_rise_clr[8*p +: 8] = PWDATA;
            if (w_acc_wr && (PADDR == 5'(8 + p))) w_fall_clr[8*p +: 8] = PWDATA;
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (PADDR == 5'(p))      w_rdata = w_live[8*p +: 8];
            if (PADDR == 5'(4 + p))  w_rdata = r_rise[8*p +: 8];
            if (PADDR == 5'(8 + p))  w_rdata = r_fall[8*p +: 8];
            if (PADDR == 5'(12 + p)) w_rdata = r_irqen[8*p +: 8];
            if (PADDR == 5'(20 + p)) w_rdata = w_head[8*p +: 8];
        end
        if (PADDR == 5'h10) w_rdata = w_stat;
        if (PADDR == 5'h11) w_rdata = {7'd0, r_capen};
    end

    // Input synchronizer, arming counter, edge flags and control registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
            r_prev   <= '0;
            r_arm    <= 3'd0;
            r_rise   <= '0;
            r_fall   <= '0;
            r_irqen  <= '0;
            r_capen  <= 1'b0;
            r_ovf    <= 1'b0;
            r_irq    <= 1'b0;
            r_prdata <= 8'h00;
        end else begin
            r_sync[0] <= PIN;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            r_prev <= w_live;
            if (!w_armed) r_arm <= r_arm + 3'd1;
            r_rise <= (r_rise & ~w_rise_clr) | w_rise_set;
            r_fall <= (r_fall & ~w_fall_clr) | w_fall_set;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_acc_wr && (PADDR == 5'(12 + p))) r_irqen[8*p +: 8] <= PWDATA;
            end
            if (w_acc_wr && (PADDR == 5'h11)) r_capen <= PWDATA[0];
            r_ovf <= w_ovf_set | (r_ovf & ~w_ovf_clr);
            r_irq <= |((r_rise | r_fall) & r_irqen);
            if (w_setup_rd) r_prdata <= w_rdata;
        end
    end

    // Snapshot FIFO bookkeeping; flush overrides any same-cycle push or pop
    always_ff @(posedge PCLK) begin
        if (PRESET || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 5'd0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 5'd1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 5'd1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (w_do_push && !w_flush && !PRESET) r_mem[r_wr_ptr] <= w_live;
    end

endmodule

// File: doc/apb_input_sampler.md
APB_INPUT_SAMPLER -- requirements
Module: apb_input_sampler

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of 8-bit input ports, legal range 1..4.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flop depth, legal range 2..4.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, snapshot FIFO entries, power of two, legal range 4..16.
REQ-004 PCLK  in  1  sole clock; all logic on its rising edge.
REQ-005 PRESET  in  1  synchronous, active-high reset.
REQ-006 PSEL, PENABLE, PWRITE  in  1 each  APB control.
REQ-007 PADDR  in  5  byte register address.
REQ-008 PWDATA  in  8  write data.
REQ-009 PRDATA  out  8  read data.
REQ-010 PREADY  out  1  transfer complete.
REQ-011 PIN  in  8*NUM_PORTS  asynchronous inputs; port p is bits [8p+7:8p].
REQ-012 IRQ  out  1  level interrupt.

Function
REQ-013 SHALL pass PIN through SYNC_STAGES flops; LIVE = last stage; PREV = LIVE delayed one cycle.
REQ-014 SHALL hold PREADY at 1: zero wait states.
REQ-015 SHALL register PRDATA in setup phase (PSEL & ~PENABLE & ~PWRITE) from PADDR, else hold; value valid through access phase.
REQ-016 SHALL perform writes and pops in access phase only (PSEL & PENABLE).
REQ-017 Register map, p < NUM_PORTS; unmapped or p >= NUM_PORTS reads 0x00, ignores writes:
- 0x00+p LIVE[p] RO.
- 0x04+p RISE[p] sticky, W1C.
- 0x08+p FALL[p] sticky, W1C.
- 0x0C+p IRQEN[p] RW.
- 0x10 STAT: [7] OVF (W1C), [6] FULL, [5] EMPTY, [4:0] COUNT; other bits ignore writes.
- 0x11 CTRL RW: [0] CAPEN, [1] FLUSH (self-clearing, reads 0).
- 0x12 POP: write (any data) pops FIFO head; reads 0x00.
- 0x14+p HEAD[p] RO: port p of FIFO head; 0x00 when empty.
REQ-018 SHALL mask edge/change detection while ARM counter < SYNC_STAGES+1; counter clears on reset, increments once per cycle, saturates.
REQ-019 When armed, SHALL set RISE bit where LIVE=1 & PREV=0, FALL bit where LIVE=0 & PREV=1.
REQ-020 Set and W1C of same flag bit in same cycle: set wins.
REQ-021 IRQ SHALL equal OR over p of ((RISE[p] | FALL[p]) & IRQEN[p]), registered (one cycle after flag/enable change).
REQ-022 When armed and CAPEN=1 and LIVE != PREV, SHALL push one entry = full LIVE vector (all ports) that cycle.
REQ-023 Push while full without pop: drop entry, set OVF; COUNT unchanged.
REQ-024 Push and pop same cycle: both take effect; COUNT unchanged, also when full; OVF not set.
REQ-025 Pop while empty: ignored, no state change.
REQ-026 FLUSH write: COUNT=0, pointers reset next cycle; wins over same-cycle push/pop; OVF unchanged.
REQ-027 Latency: PIN change sampled at edge t appears in LIVE after edge t+SYNC_STAGES-1; flag and FIFO entry visible after edge t+SYNC_STAGES.
REQ-028 FULL = (COUNT == FIFO_DEPTH); EMPTY = (COUNT == 0); COUNT SHALL be 5 bits, wide enough for 16.

Reset
REQ-029 On PRESET=1 at an edge: sync chain, LIVE, PREV, RISE, FALL, IRQEN, CTRL, OVF, FIFO pointers, COUNT, ARM, PRDATA, IRQ all 0.
REQ-030 PRESET mid-transfer SHALL abort the transfer with no register side effect; FIFO contents discarded.
REQ-031 Inputs high during reset SHALL NOT set RISE or push after reset (ARM mask, REQ-018).

Verification
REQ-032 NUM_PORTS=2, SYNC_STAGES=2, armed: PIN[0] 0->1 at edge t -> LIVE0=0x01 after t+1, RISE0=0x01 after t+2; IRQEN0=0x01 -> IRQ=1 next cycle; write 0x01 to 0x04 -> RISE0=0, IRQ=0.
REQ-033 CAPEN=1, PIN 0x0000->0x12AB -> one entry: HEAD0=0xAB, HEAD1=0x12, STAT=0x01; write 0x12 -> STAT=0x20.
REQ-034 FIFO_DEPTH=8: 9 changes with no pops -> STAT=0xC8 (OVF, FULL, COUNT=8); head = first snapshot; write 0x80 to 0x10 -> OVF=0.
REQ-035 Full FIFO, change coincident with POP -> COUNT stays 8, OVF stays 0, head advances.
REQ-036 PIN=0xFFFF held through reset release -> LIVE=0xFFFF after 2 cycles, RISE=0, COUNT=0.
REQ-037 FLUSH with COUNT=5 and same-cycle push -> STAT=0x20; unmapped read 0x1F -> 0x00.
